// File: rtl/rvfi_mem_shaper_pkg.sv
// Shared types and helpers for the RVFI memory-port fairness shaper.
package rvfi_mem_shaper_pkg;

    // Core-side protocol violation causes; only the first one is latched.
    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_DROP    = 2'd1,
        CAUSE_CHANGE  = 2'd2,
        CAUSE_BE_ZERO = 2'd3
    } viol_cause_e;

    // Width of a wait counter that counts 0..max-1; never narrower than 1 bit.
    function automatic int lat_cnt_w(input int max);
        return (max <= 2) ? 1 : $clog2(max);
    endfunction

    // Legal parameter set: every bound at least 1, data width a whole number of bytes.
    function automatic bit shaper_params_ok(input int gnt_lat, input int rsp_lat,
                                            input int max_out, input int data_w);
        return (gnt_lat >= 1) && (rsp_lat >= 1) && (max_out >= 1) &&
               (data_w >= 8) && (data_w % 8 == 0);
    endfunction

endpackage

// File: rtl/rvfi_mem_lat_cnt.sv
// Saturating wait counter; expired_o marks the last allowed wait cycle.
module rvfi_mem_lat_cnt
    import rvfi_mem_shaper_pkg::*;
#(
    parameter int MAX = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic expired_o
);
    localparam int CW = lat_cnt_w(MAX);
    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    logic [CW-1:0] cnt_q;

    // Clear wins over increment; the count sticks at LAST so the bound stays asserted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/rvfi_mem_fairness_shaper.sv
// Turns free-running random gnt/rvalid proposals into a bounded-latency
// OBI-style response for one core memory port and flags core protocol errors.
module rvfi_mem_fairness_shaper
    import rvfi_mem_shaper_pkg::*;
#(
    parameter int MAX_GNT_LAT     = 3,
    parameter int MAX_RSP_LAT     = 3,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ALLOW_ERR       = 0,
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int BE_W            = DATA_W / 8,
    parameter int OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rnd_gnt_i,
    input  logic              rnd_rvalid_i,
    input  logic              rnd_err_i,
    input  logic [DATA_W-1:0] rnd_rdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic [OUT_W-1:0]  outstanding_o,
    output logic              gnt_forced_o,
    output logic              rsp_forced_o,
    output logic              violation_o,
    output logic [1:0]        violation_cause_o
);
    if (!shaper_params_ok(MAX_GNT_LAT, MAX_RSP_LAT, MAX_OUTSTANDING, DATA_W)) begin : g_bad_params
        $error("rvfi_mem_fairness_shaper: illegal parameter set");
    end

    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);
    localparam logic             ERR_EN  = (ALLOW_ERR != 0);

    logic [OUT_W-1:0]  outstanding_q;
    logic              gnt_exp, rsp_exp;
    logic              can_gnt, busy, gnt, rvalid;

    logic              cap_vld_q, cap_we_q;
    logic [ADDR_W-1:0] cap_addr_q;
    logic [BE_W-1:0]   cap_be_q;
    logic [DATA_W-1:0] cap_wdata_q;
    logic              viol_q;
    viol_cause_e       cause_q, cause_now;
    logic              changed;

    // Grant/response decisions; reset masks everything so nothing leaks while held.
    assign can_gnt = (outstanding_q < MAX_OUT);
    assign busy    = (outstanding_q != '0);
    assign gnt     = rst_ni & req_i & can_gnt & (rnd_gnt_i | gnt_exp);
    assign rvalid  = rst_ni & busy & (rnd_rvalid_i | rsp_exp);

    assign gnt_o             = gnt;
    assign gnt_forced_o      = gnt & ~rnd_gnt_i;
    assign rvalid_o          = rvalid;
    assign rsp_forced_o      = rvalid & ~rnd_rvalid_i;
    assign rdata_o           = rvalid ? rnd_rdata_i : '0;
    assign err_o             = rvalid & ERR_EN & rnd_err_i;
    assign outstanding_o     = outstanding_q;
    assign violation_o       = viol_q;
    assign violation_cause_o = cause_q;

    // Grant wait only advances while capacity exists, so a full pipe stalls the bound.
    rvfi_mem_lat_cnt #(.MAX(MAX_GNT_LAT)) u_gnt_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inc_i     (req_i & ~gnt & can_gnt),
        .clr_i     (gnt | ~req_i),
        .expired_o (gnt_exp)
    );

    // Response wait tracks the oldest outstanding request.
    rvfi_mem_lat_cnt #(.MAX(MAX_RSP_LAT)) u_rsp_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .inc_i     (busy & ~rvalid),
        .clr_i     (rvalid | ~busy),
        .expired_o (rsp_exp)
    );

    // Outstanding count; gnt needs capacity and rvalid needs busy, so it stays in range.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_q + OUT_W'(gnt) - OUT_W'(rvalid);
        end
    end

    // Classify this cycle's violation against the request captured last cycle.
    always_comb begin
        changed = (addr_i != cap_addr_q) || (we_i != cap_we_q) || (be_i != cap_be_q) ||
                  (we_i && (wdata_i != cap_wdata_q));
        cause_now = CAUSE_NONE;
        if (cap_vld_q && !req_i) begin
            cause_now = CAUSE_DROP;
        end else if (cap_vld_q && changed) begin
            cause_now = CAUSE_CHANGE;
        end else if (req_i && (be_i == '0)) begin
            cause_now = CAUSE_BE_ZERO;
        end
    end

    // Capture ungranted requests and latch the first violation until reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cap_vld_q   <= 1'b0;
            cap_addr_q  <= '0;
            cap_we_q    <= 1'b0;
            cap_be_q    <= '0;
            cap_wdata_q <= '0;
            viol_q      <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            cap_vld_q <= req_i & ~gnt;
            if (req_i && !gnt) begin
                cap_addr_q  <= addr_i;
                cap_we_q    <= we_i;
                cap_be_q    <= be_i;
                cap_wdata_q <= wdata_i;
            end
            if (!viol_q && (cause_now != CAUSE_NONE)) begin
                viol_q  <= 1'b1;
                cause_q <= cause_now;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_mem_fairness_shaper.sv
// Directed bench for the fairness shaper; two instances differ only in ALLOW_ERR.
module tb_rvfi_mem_fairness_shaper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rd = '0;
    logic [3:0]  be = 4'hF;
    logic        rg = 1'b0, rv = 1'b0, re = 1'b0;

    logic        gnt0, rvalid0, err0, gf0, rf0, viol0;
    logic [31:0] rdata0;
    logic [1:0]  outst0, cause0;
    logic        gnt1, rvalid1, err1, gf1, rf1, viol1;
    logic [31:0] rdata1;
    logic [1:0]  outst1, cause1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rvfi_mem_fairness_shaper #(.ALLOW_ERR(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rnd_gnt_i(rg), .rnd_rvalid_i(rv),
        .rnd_err_i(re), .rnd_rdata_i(rd), .gnt_o(gnt0), .rvalid_o(rvalid0),
        .rdata_o(rdata0), .err_o(err0), .outstanding_o(outst0),
        .gnt_forced_o(gf0), .rsp_forced_o(rf0), .violation_o(viol0),
        .violation_cause_o(cause0)
    );

    rvfi_mem_fairness_shaper #(.ALLOW_ERR(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rnd_gnt_i(rg), .rnd_rvalid_i(rv),
        .rnd_err_i(re), .rnd_rdata_i(rd), .gnt_o(gnt1), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .err_o(err1), .outstanding_o(outst1),
        .gnt_forced_o(gf1), .rsp_forced_o(rf1), .violation_o(viol1),
        .violation_cause_o(cause1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset holds outputs low even with every proposal asserted
        req = 1'b1; rg = 1'b1; rv = 1'b1;
        #2;
        chk("rst_gnt", gnt0, 1'b0);
        chk("rst_rvalid", rvalid0, 1'b0);
        chk("rst_rdata", rdata0, 32'h0);
        chk("rst_gnt_forced", gf0, 1'b0);
        tick(); tick();
        rst_n = 1'b1; req = 1'b0; rg = 1'b0; rv = 1'b0;
        #1;
        chk("rst_outstanding", outst0, 2'd0);
        chk("rst_violation", viol0, 1'b0);
        chk("rst_cause", cause0, 2'd0);

        // forced grant in the 3rd request cycle, then forced response
        addr = 32'h100; req = 1'b1;
        #1 chk("fg_c0_gnt", gnt0, 1'b0);
        tick(); chk("fg_c1_gnt", gnt0, 1'b0);
        tick(); chk("fg_c2_gnt", gnt0, 1'b1);
        chk("fg_c2_forced", gf0, 1'b1);
        tick(); req = 1'b0; rd = 32'hDEADBEEF; re = 1'b1;
        #1 chk("fg_c3_outstanding", outst0, 2'd1);
        chk("fr_c3_rvalid", rvalid0, 1'b0);
        tick(); chk("fr_c4_rvalid", rvalid0, 1'b0);
        chk("fr_c4_rdata", rdata0, 32'h0);
        tick(); chk("fr_c5_rvalid", rvalid0, 1'b1);
        chk("fr_c5_forced", rf0, 1'b1);
        chk("fr_c5_rdata", rdata0, 32'hDEADBEEF);
        chk("fr_c5_err_off", err0, 1'b0);
        chk("fr_c5_err_on", err1, 1'b1);
        tick(); re = 1'b0;
        #1 chk("fr_c6_outstanding", outst0, 2'd0);

        // back-to-back grants fill capacity; no response in the granting cycle
        addr = 32'h200; req = 1'b1; rg = 1'b1; rv = 1'b1;
        #1 chk("bb_c0_gnt", gnt0, 1'b1);
        chk("bb_c0_no_rvalid", rvalid0, 1'b0);
        tick(); rv = 1'b0;
        #1 chk("bb_c1_gnt", gnt0, 1'b1);
        tick(); chk("bb_c2_outstanding", outst0, 2'd2);
        chk("bb_c2_gnt_full", gnt0, 1'b0);
        tick(); chk("bb_c3_rvalid", rvalid0, 1'b1);
        chk("bb_c3_rsp_forced", rf0, 1'b1);
        chk("bb_c3_gnt_full", gnt0, 1'b0);
        tick(); rg = 1'b0;
        #1 chk("bb_c4_outstanding", outst0, 2'd1);
        chk("bb_c4_gnt", gnt0, 1'b0);
        tick(); chk("bb_c5_gnt", gnt0, 1'b0);
        tick(); chk("bb_c6_gnt", gnt0, 1'b1);
        chk("bb_c6_rvalid", rvalid0, 1'b1);
        tick(); req = 1'b0; rv = 1'b1; re = 1'b1;
        #1 chk("bb_c7_outstanding", outst0, 2'd1);
        chk("bb_c7_rvalid", rvalid0, 1'b1);
        chk("bb_c7_err_off", err0, 1'b0);
        chk("bb_c7_err_on", err1, 1'b1);
        tick(); rv = 1'b0; re = 1'b0;
        #1 chk("bb_c8_outstanding", outst0, 2'd0);
        chk("bb_clean_violation", viol0, 1'b0);

        // dropped request latches DROP; a later change does not overwrite it
        addr = 32'h300; req = 1'b1;
        tick(); req = 1'b0;
        tick(); chk("drop_violation", viol0, 1'b1);
        chk("drop_cause", cause0, 2'd1);
        req = 1'b1; addr = 32'h304;
        tick(); addr = 32'h308;
        tick();
        tick(); chk("drop_sticky_cause", cause0, 2'd1);
        chk("drop_outstanding", outst0, 2'd1);

        // reset mid-transaction masks the response and clears everything
        rst_n = 1'b0; req = 1'b0; rv = 1'b1;
        #1 chk("rst_mid_rvalid", rvalid0, 1'b0);
        chk("rst_mid_rdata", rdata0, 32'h0);
        tick(); rst_n = 1'b1; rv = 1'b0;
        #1 chk("rst_mid_outstanding", outst0, 2'd0);
        chk("rst_mid_violation", viol0, 1'b0);
        chk("rst_mid_cause", cause0, 2'd0);

        // address change while waiting latches CHANGE
        addr = 32'h400; req = 1'b1;
        tick(); addr = 32'h404;
        tick(); chk("chg_violation", viol0, 1'b1);
        chk("chg_cause", cause0, 2'd2);
        rst_n = 1'b0; req = 1'b0;
        tick(); rst_n = 1'b1;

        // zero byte enables latch BE_ZERO even on a granted request
        req = 1'b1; be = 4'h0; rg = 1'b1;
        #1 chk("bez_gnt", gnt0, 1'b1);
        tick(); req = 1'b0; be = 4'hF; rg = 1'b0;
        #1 chk("bez_violation", viol0, 1'b1);
        chk("bez_cause", cause0, 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
